// File: rtl/hex_word_packer.sv
// Packs a stream of ASCII hex characters into right-aligned 32-bit words and
// queues them in a show-ahead FIFO; a sticky flag records protocol/lexical errors.
module hex_word_packer #(
    parameter int DEPTH      = 4,
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_back,
    input  logic [7:0]  data_in,
    output logic        full,
    input  logic        pop_front,
    output logic [31:0] data_out,
    output logic        empty,
    output logic        error
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic {
        EMPTY_ACC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    // Returns {is_digit, is_separator, nibble}; illegal characters give all zeros.
    function automatic logic [5:0] classify(input logic [7:0] ch);
        logic [5:0] r;
        r = 6'b00_0000;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            r = {2'b10, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            r = {2'b10, ch[3:0] + 4'd9};
        end else if (ch == 8'h20 || ch == 8'h09 || ch == 8'h0A || ch == 8'h0D) begin
            r = 6'b01_0000;
        end else begin
            r = 6'b00_0000;
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [31:0]     acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            error_q, error_d;
    logic [31:0]     mem_q [DEPTH];

    logic [5:0]      cls_s;
    logic [PW-1:0]   count_s;
    logic            full_s;
    logic            empty_s;
    logic            emit_s;

    assign cls_s   = classify(data_in);
    assign count_s = wr_q - rd_q;
    assign full_s  = (count_s == PW'(DEPTH));
    assign empty_s = (wr_q == rd_q);

    // Next-state for accumulator, FIFO pointers and the sticky error flag.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        error_d = error_q;
        emit_s  = 1'b0;

        if (push_back) begin
            if (full_s) begin
                error_d = 1'b1;
            end else if (cls_s[5]) begin
                if (cnt_q == CW'(MAX_DIGITS)) begin
                    error_d = 1'b1;
                end else begin
                    acc_d   = {acc_q[27:0], cls_s[3:0]};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ACCUM;
                end
            end else if (cls_s[4]) begin
                if (state_q == ACCUM) begin
                    emit_s  = 1'b1;
                    acc_d   = 32'h0000_0000;
                    cnt_d   = CW'(0);
                    state_d = EMPTY_ACC;
                    wr_d    = wr_q + PW'(1);
                end else begin
                    emit_s  = 1'b0;
                end
            end else begin
                // Illegal character abandons any partial word.
                error_d = 1'b1;
                acc_d   = 32'h0000_0000;
                cnt_d   = CW'(0);
                state_d = EMPTY_ACC;
            end
        end else begin
            emit_s = 1'b0;
        end

        if (pop_front) begin
            if (empty_s) begin
                error_d = 1'b1;
            end else begin
                rd_d = rd_q + PW'(1);
            end
        end else begin
            rd_d = rd_q;
        end
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY_ACC;
            acc_q   <= 32'h0000_0000;
            cnt_q   <= CW'(0);
            wr_q    <= PW'(0);
            rd_q    <= PW'(0);
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            error_q <= error_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers guard them.
    always_ff @(posedge clk) begin
        if (!rst && emit_s) begin
            mem_q[wr_q[AW-1:0]] <= acc_q;
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign error    = error_q;
    assign data_out = empty_s ? 32'h0000_0000 : mem_q[rd_q[AW-1:0]];

endmodule
